// File: rtl/inst_writeback.sv
// inst_writeback: writeback stage selecting ALU/load result, driving the register-file port and holding V/C/N/Z flags.
// Optional WB_FORWARD_EN mirrors the pending register write onto the fwd_* bypass outputs.
module inst_writeback #(
  parameter int LOAD_LATENCY = 2,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  rw,
  input  logic                  md,
  input  logic                  setflags,
  input  logic [REG_ADDR_W-1:0] dr,
  input  logic [31:0]           fout,
  input  logic [31:0]           memout,
  input  logic                  overflow,
  input  logic                  carryout,
  input  logic                  negative,
  input  logic                  zero,
  output logic                  busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [31:0]           rf_wd,
  output logic                  flag_v,
  output logic                  flag_c,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [31:0]           fwd_data
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] WRITE     = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] dr_q, dr_d, wa_q, wa_d;
  logic [31:0]           wd_q, wd_d;
  logic                  we_q, we_d;
  logic [3:0]            flg_q, flg_d;
  logic                  accept, is_load;
  assign accept  = valid_in && state_q == IDLE;
  assign is_load = accept && rw && md;
  // busy rises combinationally so upstream stalls in the very cycle a load is accepted
  assign busy    = is_load || state_q == LOAD_WAIT;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dr_d    = dr_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    flg_d   = (accept && setflags && !md) ? {overflow, carryout, negative, zero} : flg_q;
    case (state_q)
      IDLE: begin
        if (is_load) begin
          state_d = LOAD_WAIT;
          cnt_d   = 3'(LOAD_LATENCY - 1);
          dr_d    = dr;
        end else if (accept && rw && dr != '0) begin
          we_d = 1'b1;
          wa_d = dr;
          wd_d = fout;
        end
      end
      LOAD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = WRITE;
          if (dr_q != '0) begin
            we_d = 1'b1;
            wa_d = dr_q;
            wd_d = memout;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      dr_q    <= '0;
      wa_q    <= '0;
      wd_q    <= 32'd0;
      we_q    <= 1'b0;
      flg_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dr_q    <= dr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      flg_q   <= flg_d;
    end
  end
  assign rf_we = we_q;
  assign rf_wa = wa_q;
  assign rf_wd = wd_q;
  assign {flag_v, flag_c, flag_n, flag_z} = flg_q;
`ifdef WB_FORWARD_EN
  assign fwd_valid = we_q;
  assign fwd_addr  = wa_q;
  assign fwd_data  = wd_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = 32'd0;
`endif
endmodule

// File: tb/tb_inst_writeback.sv
// tb_inst_writeback: scoreboard-driven bench for inst_writeback; register writes are queued at issue and popped on each rf_we pulse.
module tb_inst_writeback;
  logic        clk = 1'b0;
  logic        rst_n, valid_in, rw, md, setflags;
  logic [4:0]  dr;
  logic [31:0] fout, memout;
  logic        overflow, carryout, negative, zero;
  logic        busy, rf_we, flag_v, flag_c, flag_n, flag_z, fwd_valid;
  logic [4:0]  rf_wa, fwd_addr;
  logic [31:0] rf_wd, fwd_data;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t e;
  logic [3:0] flags;
  assign flags = {flag_v, flag_c, flag_n, flag_z};

  inst_writeback #(.LOAD_LATENCY(2), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .rw(rw), .md(md), .setflags(setflags),
    .dr(dr), .fout(fout), .memout(memout), .overflow(overflow), .carryout(carryout),
    .negative(negative), .zero(zero), .busy(busy), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .flag_v(flag_v), .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic v, input logic r, input logic m, input logic sf,
                       input logic [4:0] d, input logic [31:0] f, input logic [3:0] fl);
    valid_in = v; rw = r; md = m; setflags = sf; dr = d; fout = f;
    {overflow, carryout, negative, zero} = fl;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_we === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got rf_wa=%0d rf_wd=%h, required no write", rf_wa, rf_wd);
        end else begin
          e = exp_q.pop_front();
          if (rf_wa !== e.a || rf_wd !== e.d) begin
            n_fail++;
            $display("FAIL sb_write: got rf_wa=%0d rf_wd=%h, required rf_wa=%0d rf_wd=%h", rf_wa, rf_wd, e.a, e.d);
          end
        end
      end
      n_chk++;
`ifdef WB_FORWARD_EN
      if ({fwd_valid, fwd_addr, fwd_data} !== {rf_we, rf_wa, rf_wd}) begin
`else
      if ({fwd_valid, fwd_addr, fwd_data} !== 38'd0) begin
`endif
        n_fail++;
        $display("FAIL fwd: got %b/%0d/%h with rf %b/%0d/%h", fwd_valid, fwd_addr, fwd_data, rf_we, rf_wa, rf_wd);
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    issue(0, 0, 0, 0, 5'd0, 32'd0, 4'd0);
    memout = 32'd0;
    #12;
    n_chk++;
    if ({busy, rf_we, rf_wa, rf_wd, flags, fwd_valid, fwd_addr, fwd_data} !== 81'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b we=%b wa=%0d wd=%h flags=%b fwd=%b/%0d/%h, required all 0",
               busy, rf_we, rf_wa, rf_wd, flags, fwd_valid, fwd_addr, fwd_data);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_alu_write;
    @(posedge clk); #1 issue(1, 1, 0, 0, 5'd3, 32'h0000_002A, 4'd0);
    exp_q.push_back('{5'd3, 32'h0000_002A});
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_early: got rf_we=%b, required 0", rf_we); end
    @(posedge clk); #1 issue(0, 0, 0, 0, 5'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h2A) begin
      n_fail++; $display("FAIL alu_write: got we=%b wa=%0d wd=%h, required 1/3/0000002a", rf_we, rf_wa, rf_wd);
    end
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b0 || rf_wa !== 5'd3 || rf_wd !== 32'h2A) begin
      n_fail++; $display("FAIL alu_hold: got we=%b wa=%0d wd=%h, required 0/3/0000002a", rf_we, rf_wa, rf_wd);
    end
  endtask

  task automatic test_flags;
    @(posedge clk); #1 issue(1, 0, 0, 1, 5'd0, 32'd0, 4'b1010);
    @(posedge clk); #1 issue(1, 0, 0, 0, 5'd0, 32'd0, 4'b0101);
    @(negedge clk);
    n_chk++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL flags_set: got VCNZ=%b, required 1010", flags); end
    @(posedge clk); #1 issue(1, 0, 1, 1, 5'd0, 32'd0, 4'b0101);
    @(negedge clk);
    n_chk++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL flags_hold: got VCNZ=%b, required 1010", flags); end
    @(posedge clk); #1 issue(1, 1, 0, 1, 5'd4, 32'hCAFE_0004, 4'b0101);
    exp_q.push_back('{5'd4, 32'hCAFE_0004});
    @(negedge clk);
    n_chk++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL flags_md_ignored: got VCNZ=%b, required 1010", flags); end
    @(posedge clk); #1 issue(0, 0, 0, 0, 5'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_chk++;
    if (flags !== 4'b0101 || rf_we !== 1'b1 || rf_wa !== 5'd4) begin
      n_fail++; $display("FAIL flags_with_write: got VCNZ=%b we=%b wa=%0d, required 0101/1/4", flags, rf_we, rf_wa);
    end
  endtask

  task automatic test_load;
    @(posedge clk); #1 issue(1, 1, 1, 0, 5'd5, 32'h0000_1111, 4'd0);
    memout = 32'd0;
    exp_q.push_back('{5'd5, 32'hDEAD_BEEF});
    #1;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_accept: got busy=%b, required 1", busy); end
    @(posedge clk); #1 issue(1, 1, 0, 0, 5'd9, 32'h0000_0099, 4'd0);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_1: got busy=%b, required 1", busy); end
    @(posedge clk); #1 issue(0, 0, 0, 0, 5'd0, 32'd0, 4'd0);
    memout = 32'hDEAD_BEEF;
    n_chk++;
    if (busy !== 1'b1 || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL load_busy_2: got busy=%b we=%b, required 1/0", busy, rf_we);
    end
    @(posedge clk); #1 memout = 32'd0;
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      n_fail++; $display("FAIL load_write: got we=%b wa=%0d wd=%h busy=%b, required 1/5/deadbeef/0", rf_we, rf_wa, rf_wd, busy);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL load_drain: got %0d pending writes, required 0", exp_q.size()); end
  endtask

  task automatic test_r0;
    @(posedge clk); #1 issue(1, 1, 0, 0, 5'd0, 32'hFFFF_FFFF, 4'd0);
    @(posedge clk); #1 issue(0, 0, 0, 0, 5'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b0 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL r0_suppress: got we=%b wa=%0d wd=%h, required 0/5/deadbeef", rf_we, rf_wa, rf_wd);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1 issue(1, 1, 0, 0, 5'd1, 32'h1111_0001, 4'd0);
    exp_q.push_back('{5'd1, 32'h1111_0001});
    @(posedge clk); #1 issue(1, 1, 0, 0, 5'd2, 32'h2222_0002, 4'd0);
    exp_q.push_back('{5'd2, 32'h2222_0002});
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd1 || rf_wd !== 32'h1111_0001) begin
      n_fail++; $display("FAIL b2b_r1: got we=%b wa=%0d wd=%h, required 1/1/11110001", rf_we, rf_wa, rf_wd);
    end
    @(posedge clk); #1 issue(1, 1, 0, 0, 5'd3, 32'h3333_0003, 4'd0);
    exp_q.push_back('{5'd3, 32'h3333_0003});
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd2 || rf_wd !== 32'h2222_0002) begin
      n_fail++; $display("FAIL b2b_r2: got we=%b wa=%0d wd=%h, required 1/2/22220002", rf_we, rf_wa, rf_wd);
    end
    @(posedge clk); #1 issue(0, 0, 0, 0, 5'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h3333_0003) begin
      n_fail++; $display("FAIL b2b_r3: got we=%b wa=%0d wd=%h, required 1/3/33330003", rf_we, rf_wa, rf_wd);
    end
    @(negedge clk);
    n_chk++;
    if (rf_we !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_end: got we=%b pending=%0d, required 0/0", rf_we, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load;
    @(posedge clk); #1 issue(1, 1, 1, 0, 5'd7, 32'd0, 4'd0);
    memout = 32'h7777_7777;
    @(posedge clk); #1 issue(0, 0, 0, 0, 5'd0, 32'd0, 4'd0);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_load_busy: got busy=%b, required 1", busy); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || flags !== 4'd0 || rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_load: got busy=%b VCNZ=%b we=%b wa=%0d wd=%h, required all 0", busy, flags, rf_we, rf_wa, rf_wd);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || rf_wa !== 5'd0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rst_no_write: got busy=%b wa=%0d pending=%0d, required 0/0/0", busy, rf_wa, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_alu_write;
    test_flags;
    test_load;
    test_r0;
    test_back_to_back;
    test_reset_mid_load;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
